// File: rtl/iot_pkg.sv
// ============================================================================
// Module   : iot_pkg
// Purpose  : Shared state encoding, opcode, IOP bit indices and IR fields
//            for the IOT sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package iot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_SEL  = 4'd1,
    ST_P1   = 4'd2,
    ST_W1   = 4'd3,
    ST_P2   = 4'd4,
    ST_W2   = 4'd5,
    ST_P4   = 4'd6,
    ST_W4   = 4'd7,
    ST_FIN  = 4'd8
  } state_e;

  localparam logic [2:0] OP_IOT = 3'o6;

  localparam int IOP1 = 0;
  localparam int IOP2 = 1;
  localparam int IOP4 = 2;

  localparam int IR_OP_HI  = 11;
  localparam int IR_OP_LO  = 9;
  localparam int IR_DEV_HI = 8;
  localparam int IR_DEV_LO = 3;
  localparam int IR_OPS_HI = 2;
  localparam int IR_OPS_LO = 0;

  // Lowest enabled phase in ops, or FIN when nothing is left to pulse.
  function automatic state_e first_phase(input logic [2:0] ops);
    state_e nxt;
    if (ops[IOP1])      nxt = ST_P1;
    else if (ops[IOP2]) nxt = ST_P2;
    else if (ops[IOP4]) nxt = ST_P4;
    else                nxt = ST_FIN;
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iot_dev_match.sv
// ============================================================================
// Module   : iot_dev_match
// Purpose  : Compares a 6-bit device code against the channel table and
//            returns a one-hot select (lowest channel wins) plus a hit flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iot_dev_match #(
  parameter int               NDEV     = 4,
  parameter logic [NDEV*6-1:0] DEVCODES = {6'o02, 6'o01, 6'o04, 6'o03}
) (
  input  logic [5:0]      dev_code,
  output logic [NDEV-1:0] sel,
  output logic            match
);

  logic [NDEV-1:0] hit;

  for (genvar i = 0; i < NDEV; i++) begin : g_cmp
    assign hit[i] = (dev_code == DEVCODES[6*i +: 6]);
  end

  // Two's-complement trick isolates the lowest set bit of hit.
  assign sel   = hit & (~hit + NDEV'(1));
  assign match = |hit;

endmodule

`default_nettype wire

// File: rtl/iot_sequencer.sv
// ============================================================================
// Module   : iot_sequencer
// Purpose  : Device-code decode plus timed IOP1/IOP2/IOP4 sequencing with a
//            per-channel ready handshake, optional timeout and skip collect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iot_sequencer
  import iot_pkg::*;
#(
  parameter int               NDEV     = 4,
  parameter logic [NDEV*6-1:0] DEVCODES = {6'o02, 6'o01, 6'o04, 6'o03},
  parameter int               PULSE_W  = 1,
  parameter int               TIMEOUT  = 64
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [11:0]     IR,
  input  logic            IOT_START,
  input  logic [NDEV-1:0] DEV_READY,
  input  logic [NDEV-1:0] DEV_SKIP,
  output logic [NDEV-1:0] DEV_SEL,
  output logic [2:0]      IOP,
  output logic            BUSY,
  output logic            DONE,
  output logic            SKIP,
  output logic            UNMAPPED,
  output logic            TIMEDOUT
);

  localparam int PW_W   = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW_W-1:0]   PULSE_LAST = PW_W'(PULSE_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [2:0]        ops_q, ops_d;
  logic              mapped_q, mapped_d;
  logic [PW_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              skip_flag_q, skip_flag_d;
  logic              to_flag_q, to_flag_d;
  logic [NDEV-1:0]   dev_sel_q, dev_sel_d;
  logic [2:0]        iop_q, iop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              skip_q, skip_d;
  logic              unmapped_q, unmapped_d;
  logic              timedout_q, timedout_d;

  logic [NDEV-1:0]   match_sel;
  logic              match_hit;
  logic              dev_ready;
  logic              dev_skip;
  logic              wait_expired;
  logic              phase_end;
  logic              pulse_last;

  iot_dev_match #(
    .NDEV     (NDEV),
    .DEVCODES (DEVCODES)
  ) u_match (
    .dev_code (IR[IR_DEV_HI:IR_DEV_LO]),
    .sel      (match_sel),
    .match    (match_hit)
  );

  // dev_sel_q holds the latched channel, so it also masks the handshakes.
  assign dev_ready    = |(DEV_READY & dev_sel_q);
  assign dev_skip     = |(DEV_SKIP & dev_sel_q);
  assign wait_expired = (TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST) && !dev_ready;
  assign phase_end    = dev_ready || wait_expired;
  assign pulse_last   = (pulse_cnt_q == PULSE_LAST);

  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    mapped_d    = mapped_q;
    dev_sel_d   = dev_sel_q;
    pulse_cnt_d = '0;
    wait_cnt_d  = '0;
    skip_flag_d = skip_flag_q;
    to_flag_d   = to_flag_q;

    if (state_q inside {ST_P1, ST_W1, ST_P2, ST_W2, ST_P4, ST_W4}) begin
      skip_flag_d = skip_flag_q | dev_skip;
    end

    if (state_q inside {ST_W1, ST_W2, ST_W4}) begin
      if (wait_expired) to_flag_d = 1'b1;
      if (!phase_end) begin
        wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      end
    end

    if (state_q inside {ST_P1, ST_P2, ST_P4}) begin
      if (!pulse_last) pulse_cnt_d = pulse_cnt_q + PW_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (IOT_START && (IR[IR_OP_HI:IR_OP_LO] == OP_IOT)) begin
          state_d     = ST_SEL;
          ops_d       = IR[IR_OPS_HI:IR_OPS_LO];
          mapped_d    = match_hit;
          dev_sel_d   = match_sel;
          skip_flag_d = 1'b0;
          to_flag_d   = 1'b0;
        end
      end
      ST_SEL:  state_d = mapped_q ? first_phase(ops_q) : ST_FIN;
      ST_P1:   if (pulse_last) state_d = ST_W1;
      ST_P2:   if (pulse_last) state_d = ST_W2;
      ST_P4:   if (pulse_last) state_d = ST_W4;
      ST_W1:   if (phase_end) state_d = first_phase(ops_q & 3'b110);
      ST_W2:   if (phase_end) state_d = first_phase(ops_q & 3'b100);
      ST_W4:   if (phase_end) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) dev_sel_d = '0;

    // Outputs are registered from the next state so they line up with it.
    busy_d     = (state_d != ST_IDLE);
    iop_d      = '0;
    iop_d[IOP1] = (state_d == ST_P1);
    iop_d[IOP2] = (state_d == ST_P2);
    iop_d[IOP4] = (state_d == ST_P4);
    done_d     = (state_d == ST_FIN);
    skip_d     = (state_d == ST_FIN) && skip_flag_d;
    unmapped_d = (state_d == ST_FIN) && !mapped_d;
    timedout_d = (state_d == ST_FIN) && to_flag_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      ops_q       <= '0;
      mapped_q    <= 1'b0;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      skip_flag_q <= 1'b0;
      to_flag_q   <= 1'b0;
      dev_sel_q   <= '0;
      iop_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      skip_q      <= 1'b0;
      unmapped_q  <= 1'b0;
      timedout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ops_q       <= ops_d;
      mapped_q    <= mapped_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      skip_flag_q <= skip_flag_d;
      to_flag_q   <= to_flag_d;
      dev_sel_q   <= dev_sel_d;
      iop_q       <= iop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      skip_q      <= skip_d;
      unmapped_q  <= unmapped_d;
      timedout_q  <= timedout_d;
    end
  end

  assign DEV_SEL  = dev_sel_q;
  assign IOP      = iop_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SKIP     = skip_q;
  assign UNMAPPED = unmapped_q;
  assign TIMEDOUT = timedout_q;

endmodule

`default_nettype wire

// File: tb/tb_iot_sequencer.sv
// ============================================================================
// Module   : tb_iot_sequencer
// Purpose  : Scoreboard bench for iot_sequencer: default instance plus a
//            short-timeout instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iot_sequencer;

  typedef struct {
    int start;
    int lat;
    int sel;
    int p1;
    int p2;
    int p4;
    int skip;
    int unm;
    int to;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [11:0] IR;
  logic        IOT_START, start_b;
  logic [3:0]  DEV_READY, DEV_SKIP;

  logic [3:0]  DEV_SEL, sel_b;
  logic [2:0]  IOP, iop_b;
  logic        BUSY, DONE, SKIP, UNMAPPED, TIMEDOUT;
  logic        busy_b, done_b, skip_b, unm_b, to_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  iot_sequencer u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .IR(IR), .IOT_START(IOT_START),
    .DEV_READY(DEV_READY), .DEV_SKIP(DEV_SKIP), .DEV_SEL(DEV_SEL), .IOP(IOP),
    .BUSY(BUSY), .DONE(DONE), .SKIP(SKIP), .UNMAPPED(UNMAPPED), .TIMEDOUT(TIMEDOUT)
  );

  iot_sequencer #(.TIMEOUT(3)) u_dut_to (
    .CLK(CLK), .RESET_N(RESET_N), .IR(IR), .IOT_START(start_b),
    .DEV_READY(DEV_READY), .DEV_SKIP(DEV_SKIP), .DEV_SEL(sel_b), .IOP(iop_b),
    .BUSY(busy_b), .DONE(done_b), .SKIP(skip_b), .UNMAPPED(unm_b), .TIMEDOUT(to_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic exp_t mk(int lat, int sel, int p1, int p2, int p4,
                              int sk, int un, int to);
    exp_t e;
    e.start = 0; e.lat = lat; e.sel = sel; e.p1 = p1; e.p2 = p2; e.p4 = p4;
    e.skip = sk; e.unm = un; e.to = to;
    return e;
  endfunction

  task automatic start_a(input logic [11:0] ir, input exp_t e, input bit push);
    exp_t t;
    t = e;
    IR = ir;
    IOT_START = 1'b1;
    t.start = cyc;
    if (push) qa.push_back(t);
    tick(1);
    IOT_START = 1'b0;
  endtask

  task automatic start_to(input logic [11:0] ir, input exp_t e);
    exp_t t;
    t = e;
    IR = ir;
    start_b = 1'b1;
    t.start = cyc;
    qb.push_back(t);
    tick(1);
    start_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((BUSY || busy_b || qa.size() != 0 || qb.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got timeout expected idle (qa=%0d qb=%0d)", qa.size(), qb.size());
    end
    tick(1);
  endtask

  // Monitor for the default instance: tracks select/pulse history per sequence.
  int first_iop[3];
  int cnt_iop[3];
  int sel_seen;
  int sel_first;

  task automatic clear_track();
    for (int b = 0; b < 3; b++) begin
      first_iop[b] = -1;
      cnt_iop[b]   = 0;
    end
    sel_seen  = 0;
    sel_first = -1;
  endtask

  function automatic int rel(int abs_c, int start);
    return (abs_c < 0) ? -1 : abs_c - start;
  endfunction

  initial clear_track();

  always @(negedge CLK) begin
    if (!RESET_N) begin
      clear_track();
    end else begin
      if (DEV_SEL != 4'd0) begin
        sel_seen = sel_seen | int'(DEV_SEL);
        if (sel_first < 0) sel_first = cyc;
      end
      for (int b = 0; b < 3; b++) begin
        if (IOP[b]) begin
          if (first_iop[b] < 0) first_iop[b] = cyc;
          cnt_iop[b]++;
        end
      end
      if (DONE) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("done_latency", cyc - e.start, e.lat);
          check("dev_sel", sel_seen, e.sel);
          check("dev_sel_first_cycle", rel(sel_first, e.start), (e.sel != 0) ? 1 : -1);
          check("iop1_cycle", rel(first_iop[0], e.start), e.p1);
          check("iop2_cycle", rel(first_iop[1], e.start), e.p2);
          check("iop4_cycle", rel(first_iop[2], e.start), e.p4);
          check("iop1_width", cnt_iop[0], (e.p1 >= 0) ? 1 : 0);
          check("iop2_width", cnt_iop[1], (e.p2 >= 0) ? 1 : 0);
          check("iop4_width", cnt_iop[2], (e.p4 >= 0) ? 1 : 0);
          check("skip", int'(SKIP), e.skip);
          check("unmapped", int'(UNMAPPED), e.unm);
          check("timedout", int'(TIMEDOUT), e.to);
        end
        clear_track();
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET_N && done_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done_to: got DONE=1 expected no DONE (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("to_done_latency", cyc - e.start, e.lat);
        check("to_dev_sel", int'(sel_b), e.sel);
        check("to_skip", int'(skip_b), e.skip);
        check("to_unmapped", int'(unm_b), e.unm);
        check("to_timedout", int'(to_b), e.to);
      end
    end
  end

  initial begin
    RESET_N   = 1'b0;
    IR        = 12'o0;
    IOT_START = 1'b0;
    start_b   = 1'b0;
    DEV_READY = 4'b0000;
    DEV_SKIP  = 4'b0000;
    tick(2);
    check("reset_outputs", int'({DEV_SEL, IOP, BUSY, DONE, SKIP, UNMAPPED, TIMEDOUT}), 0);
    check("reset_outputs_to", int'({sel_b, iop_b, busy_b, done_b, skip_b, unm_b, to_b}), 0);
    RESET_N = 1'b1;
    tick(2);

    // Code 04 -> ch1, IOP2+IOP4, ready tied high.
    DEV_READY = 4'b1111;
    start_a(12'o6046, mk(6, 4'b0010, -1, 2, 4, 0, 0, 0), 1'b1);
    wait_idle();

    // Code 03 -> ch0, IOP1 with skip raised only during P1.
    start_a(12'o6031, mk(4, 4'b0001, 2, -1, -1, 1, 0, 0), 1'b1);
    tick(1);
    DEV_SKIP = 4'b0001;
    tick(1);
    DEV_SKIP = 4'b0000;
    wait_idle();

    // Skips on unselected channels must not leak into the result.
    start_a(12'o6031, mk(4, 4'b0001, 2, -1, -1, 0, 0, 0), 1'b1);
    DEV_SKIP = 4'b1110;
    wait_idle();
    DEV_SKIP = 4'b0000;

    // ch1 ready withheld for five W1 cycles; other channels ready.
    DEV_READY = 4'b1101;
    start_a(12'o6041, mk(9, 4'b0010, 2, -1, -1, 0, 0, 0), 1'b1);
    tick(7);
    DEV_READY = 4'b1111;
    wait_idle();

    // Short-timeout instance with ready stuck low.
    DEV_READY = 4'b0000;
    start_to(12'o6041, mk(6, 4'b0010, 2, -1, -1, 0, 0, 1));
    wait_idle();

    // Unmapped code 17 must not wait on ready.
    start_a(12'o6177, mk(2, 0, -1, -1, -1, 0, 1, 0), 1'b1);
    wait_idle();
    DEV_READY = 4'b1111;

    // Second start while busy, with a different IR, is ignored.
    start_a(12'o6046, mk(6, 4'b0010, -1, 2, 4, 0, 0, 0), 1'b1);
    tick(1);
    IR = 12'o6031;
    IOT_START = 1'b1;
    tick(1);
    IOT_START = 1'b0;
    wait_idle();

    // Non-IOT opcode is ignored.
    IR = 12'o7200;
    IOT_START = 1'b1;
    tick(1);
    IOT_START = 1'b0;
    tick(1);
    check("opc7_ignored_busy", int'(BUSY), 0);
    tick(4);

    // Reset in P2 aborts silently; the next sequence runs normally.
    start_a(12'o6046, mk(0, 0, -1, -1, -1, 0, 0, 0), 1'b0);
    tick(1);
    check("iop2_before_reset", int'(IOP), 3'b010);
    RESET_N = 1'b0;
    #1;
    check("abort_outputs", int'({DEV_SEL, IOP, BUSY, DONE, SKIP, UNMAPPED, TIMEDOUT}), 0);
    tick(2);
    RESET_N = 1'b1;
    tick(1);
    start_a(12'o6027, mk(8, 4'b1000, 2, 4, 6, 0, 0, 0), 1'b1);
    wait_idle();

    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iot_sequencer.md
Name: iot_sequencer

Overview:
- Parametrised successor to the fixed IOT 600x/62xx base decoder.
- Decodes the 6-bit device code IR[8:3] against a configurable table of NDEV device channels and drives a registered one-hot device select.
- Sequences the classic IOP1/IOP2/IOP4 pulses (IR[0], IR[1], IR[2]) as timed phases, with a per-device ready handshake and optional timeout.
- Collects device skip responses and returns a single DONE/SKIP result to the CPU execute sequencer.

Parameters:
- NDEV, 4: number of device channels (1..16).
- DEVCODES, {6'o02,6'o01,6'o04,6'o03}: packed NDEV*6 bits; channel i code at [6i+5:6i]. Default: ch0=03, ch1=04, ch2=01, ch3=02.
- PULSE_W, 1: cycles each IOP pulse is held high (>=1).
- TIMEOUT, 64: max wait cycles for DEV_READY per phase; 0 means wait forever.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- IR  in  12  instruction register; IR[11:9]=3'o6 for IOT, IR[8:3] device code, IR[2:0] IOP enables
- IOT_START  in  1  one-cycle strobe from the CPU: IOT execute begins, IR valid this cycle
- DEV_READY  in  NDEV  per-channel "pulse accepted" handshake
- DEV_SKIP  in  NDEV  per-channel skip request
- DEV_SEL  out  NDEV  registered one-hot select of the matched channel
- IOP  out  3  registered pulses; bit0=IOP1, bit1=IOP2, bit2=IOP4
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse to the CPU
- SKIP  out  1  OR of sampled skips; valid while DONE=1
- UNMAPPED  out  1  no channel matched; valid while DONE=1
- TIMEDOUT  out  1  at least one phase timed out; valid while DONE=1

Behaviour:
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE. Reset is asynchronous and aborts any sequence mid-operation, with no DONE issued.
- States: IDLE, SEL, P1, W1, P2, W2, P4, W4, FIN.
- IDLE: on IOT_START=1 with IR[11:9]=3'o6, latch IR[8:0] and the match result, then go to SEL. IOT_START with any other opcode is ignored.
- Matching: channel i matches when IR[8:3]==DEVCODES[i]. If several channels match, the lowest index wins.
- SEL: BUSY=1 and DEV_SEL asserted; DEV_SEL stays asserted through FIN.
  - Unmapped device: go to FIN with UNMAPPED=1. No DEV_SEL, no IOP pulses.
  - Mapped device: go to the first enabled phase among P1, P2, P4, or to FIN if IR[2:0]=0.
- Pn: IOP bit driven high for exactly PULSE_W cycles, then Wn.
- Wn: IOP low; wait for DEV_READY[sel]=1 (1 cycle minimum), then go to the next enabled phase or FIN.
  - If TIMEOUT>0 and the wait reaches TIMEOUT cycles, set the sticky TIMEDOUT flag and advance anyway.
- Disabled phases consume zero cycles.
- Skip: DEV_SKIP[sel] is sampled in every Pn and Wn cycle and ORed into a sticky flag, cleared on entry to SEL.
- FIN: DONE=1 for one cycle with SKIP, UNMAPPED and TIMEDOUT valid. Next state IDLE; BUSY, DEV_SEL and the result flags clear.
- Latency: DONE asserts in cycle 2 + sum over enabled phases of (PULSE_W + wait cycles), counting from the IOT_START cycle as cycle 0. Wait cycles are >=1.
- IOT_START while BUSY is ignored. There is no queueing.
- DEV_READY/DEV_SKIP on unselected channels are ignored.
- Pulse and wait counters are sized by $clog2. The wait counter saturates and does not wrap.

Decomposition:
- Package iot_pkg: state encoding, OP_IOT=3'o6, IOP bit indices (IOP1=0, IOP2=1, IOP4=2), field slice constants for IR.
- Sub-module iot_dev_match: combinational compare of IR[8:3] against DEVCODES, with a priority encoder producing one-hot select and a match flag.
- The FSM, counters and flags live in iot_sequencer.

Test Plan:
1. Reset mid-sequence: assert RESET_N=0 while in P2 -> all outputs 0 immediately, no DONE; the next IOT_START runs normally.
2. IR=12'o6046, READY tied 1, PULSE_W=1:
   - DEV_SEL=4'b0010 from cycle 1.
   - IOP2 high in cycle 2, IOP4 high in cycle 4.
   - DONE in cycle 6 with SKIP=0.
3. IR=12'o6031, DEV_SKIP[0]=1 during P1, READY=1 -> IOP1 in cycle 2; DONE in cycle 4 with SKIP=1.
4. IR=12'o6041, DEV_READY[1] held 0 for 5 cycles after the pulse -> W1 lasts 6 cycles, DONE in cycle 9, TIMEDOUT=0. With TIMEOUT=3 and READY stuck at 0 -> DONE in cycle 6, TIMEDOUT=1.
5. IR=12'o6177 (unmapped code 17) -> DEV_SEL=0 and IOP=0 throughout; DONE in cycle 2 with UNMAPPED=1.
6. Second IOT_START during BUSY, and IOT_START with IR=12'o7200 -> both ignored; the in-flight result is unchanged.
